// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the E stage; optional MDU_DIV0_FAST_EN finishes divide-by-zero early.
// Latency: multiply MUL_CYCLES cycles from accept to done, divide 34 cycles (1 cycle for b==0 with MDU_DIV0_FAST_EN).
// Backpressure: none accepted; busy stalls the pipeline from the accept cycle until the done cycle.
module mdu_iter #(
    parameter int MUL_CYCLES = 2,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} stateT;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(WIDTH);

    stateT state, nextState;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] aReg, bReg, magB, quoReg;
    logic [WIDTH:0]   remReg;
    logic             mulSgn, negQ, negR, bZero;

    logic             accept, div0Fast;
    logic [WIDTH-1:0] magAIn, magBIn, mulA, mulB, qFix, rFix;
    logic             mulSgnSel;
    logic [2*WIDTH-1:0] extA, extB, prod, divRes;
    logic [WIDTH:0]   shifted, remNext;
    logic             geq;

    assign accept = (state == IDLE) & start & ~flush;

`ifdef MDU_DIV0_FAST_EN
    assign div0Fast = op[1] & (b == '0);
`else
    assign div0Fast = 1'b0;
`endif

    // Operand magnitudes for the unsigned divide core (0x80000000 stays 0x80000000).
    assign magAIn = (~op[0] & a[WIDTH-1]) ? -a : a;
    assign magBIn = (~op[0] & b[WIDTH-1]) ? -b : b;

    // Product source: live inputs in the accept cycle (single-cycle multiply), latched operands afterwards.
    assign mulA      = (state == IDLE) ? a : aReg;
    assign mulB      = (state == IDLE) ? b : bReg;
    assign mulSgnSel = (state == IDLE) ? ~op[0] : mulSgn;
    assign extA      = {{WIDTH{mulSgnSel & mulA[WIDTH-1]}}, mulA};
    assign extB      = {{WIDTH{mulSgnSel & mulB[WIDTH-1]}}, mulB};
    assign prod      = extA * extB;

    // One restoring step: shift in the next dividend bit, subtract divisor when it fits.
    assign shifted = (remReg << 1) | {{WIDTH{1'b0}}, quoReg[WIDTH-1]};
    assign geq     = shifted >= {1'b0, magB};
    assign remNext = geq ? (shifted - {1'b0, magB}) : shifted;

    // Sign fix-up, with the forced result for a zero divisor.
    assign qFix   = negQ ? -quoReg : quoReg;
    assign rFix   = negR ? -remReg[WIDTH-1:0] : remReg[WIDTH-1:0];
    assign divRes = bZero ? {aReg, {WIDTH{1'b1}}} : {rFix, qFix};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    // Next-state, stall and completion decode.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    busy = 1'b1;
                    if (op[1])               nextState = div0Fast ? DONE : DIV;
                    else if (MUL_CYCLES == 1) nextState = DONE;
                    else                      nextState = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (flush)                 nextState = IDLE;
                else if (cnt == MUL_LAST)  nextState = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (flush)                 nextState = IDLE;
                else if (cnt == DIV_LAST)  nextState = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                nextState = flush ? IDLE : DONE;
            end
            DONE: begin
                done      = ~flush;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (!resetn) busy = 1'b0;
    end

    // Operand capture, cycle counter, divide iterations and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            aReg   <= '0;
            bReg   <= '0;
            magB   <= '0;
            quoReg <= '0;
            remReg <= '0;
            mulSgn <= 1'b0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
            bZero  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        aReg   <= a;
                        bReg   <= b;
                        magB   <= magBIn;
                        quoReg <= magAIn;
                        remReg <= '0;
                        mulSgn <= ~op[0];
                        negQ   <= (op == 2'b10) & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negR   <= (op == 2'b10) & a[WIDTH-1];
                        bZero  <= (b == '0);
                        cnt    <= 6'd1;
                    end
                end
                MUL: cnt <= (nextState == MUL) ? cnt + 6'd1 : 6'd0;
                DIV: begin
                    if (!flush) begin
                        remReg <= remNext;
                        quoReg <= {quoReg[WIDTH-2:0], geq};
                    end
                    cnt <= (nextState == DIV) ? cnt + 6'd1 : 6'd0;
                end
                default: cnt <= '0;
            endcase
            if (nextState == DONE && state != DONE) begin
                if (state == FIX)                     {hi, lo} <= divRes;
                else if (state == IDLE && op[1])      {hi, lo} <= {a, {WIDTH{1'b1}}};
                else                                  {hi, lo} <= prod;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: cycle-level reference model plus directed literal checks and randomized operations.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_iter;
    localparam int MC = 2;

    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0, errors = 0;
    int cycNow = 0;

    // Reference model state: 0 idle, 1 computing, 2 result cycle.
    int          mPhase = 0, mLeft = 0;
    logic [63:0] mPend = '0, mRes = '0;

    mdu_iter #(.MUL_CYCLES(MC), .WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycNow++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cycNow);
        end
    endtask

    function automatic logic [63:0] refRes(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        u  = '0;
        case (o)
            2'b00: begin p = sx * sy; u = p; end
            2'b01: u = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) u = {x, 32'hFFFFFFFF};
                else begin q = sx / sy; r = sx % sy; u = {r[31:0], q[31:0]}; end
            end
            default: u = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
        endcase
        return u;
    endfunction

    function automatic int refLat(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return MC;
`ifdef MDU_DIV0_FAST_EN
        if (y == 0) return 1;
`endif
        return 34;
    endfunction

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        int lat;
        if (!resetn) begin
            chk("rst_busy", {63'b0, busy}, 64'd0);
            chk("rst_done", {63'b0, done}, 64'd0);
            chk("rst_hilo", {hi, lo}, 64'd0);
            mPhase = 0; mLeft = 0; mRes = '0;
        end else begin
            chk("busy", {63'b0, busy}, {63'b0, (mPhase == 0 && start && !flush) || mPhase == 1});
            chk("done", {63'b0, done}, {63'b0, mPhase == 2 && !flush});
            chk("hilo", {hi, lo}, mRes);
            case (mPhase)
                2: mPhase = 0;
                1: begin
                    if (flush) mPhase = 0;
                    else begin
                        mLeft--;
                        if (mLeft == 0) begin mPhase = 2; mRes = mPend; end
                    end
                end
                default: begin
                    if (start && !flush) begin
                        lat   = refLat(op, b);
                        mPend = refRes(op, a, b);
                        if (lat == 1) begin mPhase = 2; mRes = mPend; end
                        else begin mPhase = 1; mLeft = lat - 1; end
                    end
                end
            endcase
        end
    end

    // Issue one operation (start held until its result cycle); flushAt<0 means no flush.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int flushAt,
                         output int doneCyc, output int doneAbs, output logic [63:0] res);
        op = o; a = x; b = y; start = 1'b1; flush = 1'b0;
        doneCyc = -1; doneAbs = -1; res = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == flushAt) flush = 1'b1;
            if (flushAt >= 0 && cyc == flushAt + 1) begin flush = 1'b0; start = 1'b0; end
            @(negedge clk);
            if (done) begin doneCyc = cyc; doneAbs = cycNow; res = {hi, lo}; break; end
            if (flushAt >= 0 && cyc == flushAt + 1) break;
            @(posedge clk); #1;
        end
        if (flushAt < 0) chk("done_seen", {63'b0, doneCyc >= 0}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, da, da2, lat, fa;
        logic [63:0] r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        runOp(2'b00, 32'hFFFFFFFE, 32'd3, -1, dc, da, r);
        chk("mult_cyc", 64'(dc), 64'(MC));
        chk("mult_res", r, 64'hFFFFFFFF_FFFFFFFA);

        runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, dc, da, r);
        chk("multu_res", r, 64'hFFFFFFFE_00000001);

        runOp(2'b10, 32'hFFFFFFF9, 32'd2, -1, dc, da, r);
        chk("div_cyc", 64'(dc), 64'd34);
        chk("div_res", r, 64'hFFFFFFFF_FFFFFFFD);

        runOp(2'b11, 32'd100, 32'd7, 10, dc, da, r);
        chk("flush_nodone", 64'(dc), 64'hFFFFFFFF_FFFFFFFF);
        chk("flush_idle", {63'b0, busy}, 64'd0);
        chk("flush_hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        runOp(2'b11, 32'd100, 32'd7, -1, dc, da, r);
        chk("divu_cyc", 64'(dc), 64'd34);
        chk("divu_res", r, 64'h00000002_0000000E);

        runOp(2'b10, 32'h12345678, 32'd0, -1, dc, da, r);
`ifdef MDU_DIV0_FAST_EN
        chk("div0_cyc", 64'(dc), 64'd1);
`else
        chk("div0_cyc", 64'(dc), 64'd34);
`endif
        chk("div0_res", r, 64'h12345678_FFFFFFFF);

        runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, dc, da, r);
        chk("ovf_res", r, 64'h00000000_80000000);
        runOp(2'b00, 32'd5, 32'd6, -1, dc, da2, r);
        chk("b2b_res", r, 64'd30);
        chk("b2b_gap", 64'(da2 - da), 64'(MC + 1));

        // Reset in the middle of a divide.
        op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
        repeat (6) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        start = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Randomized operations, occasional flushes and idle-cycle flush/start collisions.
        for (int i = 0; i < 200; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            lat = refLat(ro, rb);
            fa  = ($urandom_range(0, 5) == 0 && lat > 1) ? int'($urandom_range(1, lat)) : -1;
            runOp(ro, ra, rb, fa, dc, da, r);
            if (fa < 0) chk("rand_res", r, refRes(ro, ra, rb));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; flush = 1'b1; a = $urandom; b = $urandom;
                @(posedge clk); #1;
                start = 1'b0; flush = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
